instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: Width, default 32, width of the instruction word and of the addresses.
REQ-002 Ports (name direction width meaning):
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  encode request present.
- req_ready  out  1  encoder can accept a request.
- req_fmt  in  3  format: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 reserved.
- req_op  in  4  operation code, decoded per format.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  Width  signed immediate or byte offset.
- base_load  in  1  loads base_addr into the address pointer.
- base_addr  in  Width  new program base address.
- instr_valid  out  1  encoded word at the FIFO head.
- instr_ready  in  1  consumer accepts the head word.
- instr  out  Width  encoded RISC-V instruction.
- instr_addr  out  Width  instruction-memory address of the head word.
- err_pulse  out  1  one-cycle flag for an illegal request.
- err_cnt  out  8  saturating count of illegal requests.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-004 A request SHALL be accepted on a clock edge where req_valid and req_ready are both high; req_ready SHALL equal (fifo_count < 2).
REQ-005 Each legal accepted request SHALL be written to a 2-entry FIFO on the acceptance edge. The FIFO entry SHALL hold {instr, addr}. There SHALL be no combinational path from request to output, so the minimum latency is 1 cycle.
REQ-006 instr_valid SHALL equal (fifo_count > 0). The head entry SHALL pop on an edge where instr_valid and instr_ready are both high.
REQ-007 Pop and push SHALL be allowed on the same edge. When the FIFO is full, req_ready SHALL stay low even if instr_ready is high (no pass-through).
REQ-008 R format: opcode 0110011, rd in [11:7], rs1 in [19:15], rs2 in [24:20].
- req_op 0..9 SHALL map to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- funct3 SHALL be 000, 000, 001, 010, 011, 100, 101, 101, 110, 111 respectively.
- funct7 SHALL be 0100000 for SUB and SRA, and 0000000 otherwise.
- req_op greater than 9 SHALL be illegal.
REQ-009 I-ALU format: opcode 0010011.
- req_op 0 SHALL encode ADDI (funct3 000, imm[11:0] in [31:20]); legal only if req_imm lies in -2048..2047.
- req_op 2 SHALL encode SLLI (funct3 001, funct7 0, shamt in [24:20]); legal only if req_imm lies in 0..31.
- All other req_op values SHALL be illegal.
REQ-010 LOAD format: opcode 0000011, funct3 = req_op[2:0], imm[11:0] in [31:20]. Legal only if funct3 is 000, 001 or 010 and req_op[3] is 0.
REQ-011 STORE format: opcode 0100011, imm[11:5] in [31:25], imm[4:0] in [11:7]. The funct3 legality and immediate range SHALL be as for LOAD.
REQ-012 BRANCH format: opcode 1100011; req_op 0 SHALL encode BEQ (funct3 000) and req_op 1 BNE (funct3 001).
- Bit placement: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
- Legal only if req_imm lies in -4096..4094 and req_imm[0] is 0.
REQ-013 JAL format: opcode 1101111, rd in [11:7].
- Bit placement: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
- Legal only if req_imm is even and lies in -1048576..1048574.
REQ-014 JALR format: opcode 1100111, funct3 000, imm[11:0] in [31:20], with the 12-bit immediate range. req_fmt 7 SHALL be illegal.
REQ-015 Address pointer:
- Each legal push SHALL store the current pointer as addr, and the pointer SHALL then advance by 4, wrapping modulo 2^Width.
- Illegal requests SHALL NOT advance the pointer.
REQ-016 base_load SHALL take priority over any push in the same cycle.
- A simultaneous legal push SHALL use base_addr as its addr, and the pointer SHALL become base_addr+4.
- Otherwise the pointer SHALL become base_addr.
- base_load SHALL NOT change entries already in the FIFO.
REQ-017 An illegal accepted request SHALL complete the handshake but SHALL NOT be pushed.
- err_pulse SHALL go high for exactly the next cycle.
- err_cnt SHALL increment and saturate at 255.

Reset
REQ-018 While rst_n is low, the block SHALL hold: fifo_count 0, pointer 0, instr_valid 0, req_ready 0, instr 0, instr_addr 0, err_pulse 0, err_cnt 0. req_ready SHALL rise on the first edge after rst_n deasserts.
REQ-019 Reset asserted mid-operation SHALL discard all FIFO contents immediately, with no partial pop.

Verification
REQ-020 The bench SHALL cover:
- Reset, then R ADD rd=1 rs1=2 rs2=3 -> one cycle later instr=0x003100B3, instr_addr=0, instr_valid=1.
- SUB with the same registers, then BNE rs1=1 rs2=0 imm=-8 -> instr 0x403100B3 at addr 0, then 0xFE009CE3 at addr 4.
- instr_ready held low while 3 requests are offered -> req_ready drops after 2; with pop and push on the same edge, ordering is preserved.
- ADDI imm=2048, BRANCH imm=3, fmt 7 -> three err_pulses, err_cnt=3, pointer unchanged, no FIFO entries.
- base_load with base_addr=0x100 together with a JAL rd=1 imm=8 -> instr 0x008000EF, instr_addr=0x100, next addr 0x104.
- 256 illegal requests -> err_cnt saturates at 255.

Source files
------------

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request, instruction-stream and error signals of the instruction encoder
interface instr_encoder_if #(
    parameter int Width = 32
);
    // Request side
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_fmt;
    logic [3:0]       req_op;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [Width-1:0] req_imm;

    // Program base reload
    logic             base_load;
    logic [Width-1:0] base_addr;

    // Encoded instruction stream
    logic             instr_valid;
    logic             instr_ready;
    logic [Width-1:0] instr;
    logic [Width-1:0] instr_addr;

    // Illegal-request reporting
    logic             err_pulse;
    logic [7:0]       err_cnt;

    modport master (
        output req_valid, req_fmt, req_op, req_rd, req_rs1, req_rs2, req_imm,
        output base_load, base_addr, instr_ready,
        input  req_ready, instr_valid, instr, instr_addr, err_pulse, err_cnt
    );

    modport slave (
        input  req_valid, req_fmt, req_op, req_rd, req_rs1, req_rs2, req_imm,
        input  base_load, base_addr, instr_ready,
        output req_ready, instr_valid, instr, instr_addr, err_pulse, err_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with address pointer, 2-entry output FIFO and error counter
module instr_encoder #(
    parameter int Width = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_encoder_if.slave bus
);

    // Request formats
    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;
    localparam logic [2:0] FMT_JAL    = 3'd5;
    localparam logic [2:0] FMT_JALR   = 3'd6;

    // Major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Immediate limits, held at full word width so the comparisons stay signed
    localparam logic signed [Width-1:0] IMM12_MIN = Width'(-2048);
    localparam logic signed [Width-1:0] IMM12_MAX = Width'(2047);
    localparam logic signed [Width-1:0] SHAMT_MAX = Width'(31);
    localparam logic signed [Width-1:0] BR_MIN    = Width'(-4096);
    localparam logic signed [Width-1:0] BR_MAX    = Width'(4094);
    localparam logic signed [Width-1:0] JAL_MIN   = Width'(-1048576);
    localparam logic signed [Width-1:0] JAL_MAX   = Width'(1048574);
    localparam logic signed [Width-1:0] ZERO_S    = '0;

    localparam logic [Width-1:0] ADDR_STEP = Width'(4);

    // Decode results
    logic signed [Width-1:0] imm_s;
    logic                    imm12_ok;
    logic                    shamt_ok;
    logic                    br_ok;
    logic                    jal_ok;
    logic                    mem_f3_ok;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [31:0]             enc_word;
    logic                    enc_legal;
    logic [Width-1:0]        enc_ext;

    // Handshake and datapath controls
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    bad;
    logic [Width-1:0]        push_addr;

    // State
    logic                    ready_en_q, ready_en_d;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [Width-1:0]        fifo_instr_q [2];
    logic [Width-1:0]        fifo_instr_d [2];
    logic [Width-1:0]        fifo_addr_q  [2];
    logic [Width-1:0]        fifo_addr_d  [2];
    logic [Width-1:0]        ptr_q, ptr_d;
    logic                    err_pulse_q, err_pulse_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    assign imm_s = $signed(bus.req_imm);

    // Immediate range checks shared by the formats
    always_comb begin
        imm12_ok  = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
        shamt_ok  = (imm_s >= ZERO_S) && (imm_s <= SHAMT_MAX);
        br_ok     = (imm_s >= BR_MIN) && (imm_s <= BR_MAX) && !bus.req_imm[0];
        jal_ok    = (imm_s >= JAL_MIN) && (imm_s <= JAL_MAX) && !bus.req_imm[0];
        mem_f3_ok = !bus.req_op[3] && (bus.req_op[2:0] <= 3'd2);
    end

    // Build the 32-bit instruction word and its legality from the request fields
    always_comb begin
        funct3    = 3'b000;
        funct7    = 7'b0000000;
        enc_word  = '0;
        enc_legal = 1'b0;
        case (bus.req_fmt)
            FMT_R: begin
                enc_legal = (bus.req_op <= 4'd9);
                case (bus.req_op)
                    4'd0: funct3 = 3'b000;
                    4'd1: begin funct3 = 3'b000; funct7 = F7_ALT; end
                    4'd2: funct3 = 3'b001;
                    4'd3: funct3 = 3'b010;
                    4'd4: funct3 = 3'b011;
                    4'd5: funct3 = 3'b100;
                    4'd6: funct3 = 3'b101;
                    4'd7: begin funct3 = 3'b101; funct7 = F7_ALT; end
                    4'd8: funct3 = 3'b110;
                    4'd9: funct3 = 3'b111;
                    default: funct3 = 3'b000;
                endcase
                enc_word = {funct7, bus.req_rs2, bus.req_rs1, funct3, bus.req_rd, OPC_R};
            end
            FMT_I: begin
                if (bus.req_op == 4'd2) begin
                    enc_legal = shamt_ok;
                    enc_word  = {7'b0000000, bus.req_imm[4:0], bus.req_rs1, 3'b001,
                                 bus.req_rd, OPC_I};
                end else begin
                    enc_legal = (bus.req_op == 4'd0) && imm12_ok;
                    enc_word  = {bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OPC_I};
                end
            end
            FMT_LOAD: begin
                enc_legal = mem_f3_ok && imm12_ok;
                enc_word  = {bus.req_imm[11:0], bus.req_rs1, bus.req_op[2:0],
                             bus.req_rd, OPC_LOAD};
            end
            FMT_STORE: begin
                enc_legal = mem_f3_ok && imm12_ok;
                enc_word  = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_op[2:0],
                             bus.req_imm[4:0], OPC_STORE};
            end
            FMT_BRANCH: begin
                enc_legal = (bus.req_op <= 4'd1) && br_ok;
                funct3    = {2'b00, bus.req_op[0]};
                enc_word  = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                             funct3, bus.req_imm[4:1], bus.req_imm[11], OPC_BRANCH};
            end
            FMT_JAL: begin
                enc_legal = jal_ok;
                enc_word  = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                             bus.req_imm[19:12], bus.req_rd, OPC_JAL};
            end
            FMT_JALR: begin
                enc_legal = imm12_ok;
                enc_word  = {bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OPC_JALR};
            end
            default: begin
                enc_legal = 1'b0;
                enc_word  = '0;
            end
        endcase
    end

    // Widen the encoded word to the FIFO data width
    always_comb begin
        enc_ext       = '0;
        enc_ext[31:0] = enc_word;
    end

    // Handshake decode; req_ready is held low until the first edge out of reset
    always_comb begin
        bus.req_ready   = ready_en_q && (count_q < 2'd2);
        bus.instr_valid = (count_q != 2'd0);
        accept          = bus.req_valid && bus.req_ready;
        push            = accept && enc_legal;
        bad             = accept && !enc_legal;
        pop             = bus.instr_valid && bus.instr_ready;
        push_addr       = bus.base_load ? bus.base_addr : ptr_q;
    end

    // Next-state for FIFO, address pointer and error reporting
    always_comb begin
        ready_en_d   = 1'b1;
        fifo_instr_d = fifo_instr_q;
        fifo_addr_d  = fifo_addr_q;
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            fifo_instr_d[wr_ptr_q] = enc_ext;
            fifo_addr_d[wr_ptr_q]  = push_addr;
        end

        if (push) begin
            ptr_d = push_addr + ADDR_STEP;
        end else if (bus.base_load) begin
            ptr_d = bus.base_addr;
        end else begin
            ptr_d = ptr_q;
        end

        err_pulse_d = bad;
        if (bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers; reset drops every FIFO entry at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q      <= 1'b0;
            count_q         <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
            fifo_addr_q[0]  <= '0;
            fifo_addr_q[1]  <= '0;
            ptr_q           <= '0;
            err_pulse_q     <= 1'b0;
            err_cnt_q       <= 8'd0;
        end else begin
            ready_en_q      <= ready_en_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fifo_instr_q    <= fifo_instr_d;
            fifo_addr_q     <= fifo_addr_d;
            ptr_q           <= ptr_d;
            err_pulse_q     <= err_pulse_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    // Head entry and error outputs come straight from flops
    always_comb begin
        bus.instr      = fifo_instr_q[rd_ptr_q];
        bus.instr_addr = fifo_addr_q[rd_ptr_q];
        bus.err_pulse  = err_pulse_q;
        bus.err_cnt    = err_cnt_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    instr_encoder_if #(.Width(32)) bus ();

    instr_encoder #(.Width(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bus.req_valid = 1'b1;
        bus.req_fmt   = fmt;
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_imm   = imm;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_fmt   = 3'd0;
        bus.req_op    = 4'd0;
        bus.req_rd    = 5'd0;
        bus.req_rs1   = 5'd0;
        bus.req_rs2   = 5'd0;
        bus.req_imm   = 32'd0;
        bus.base_load = 1'b0;
        bus.base_addr = 32'd0;
        bus.instr_ready = 1'b0;

        // Reset values
        tick();
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_addr", bus.instr_addr, 32'h0);
        check("rst_err_pulse", bus.err_pulse, 1'b0);
        check("rst_err_cnt", bus.err_cnt, 8'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", bus.req_ready, 1'b0);
        tick();
        check("ready_after_edge", bus.req_ready, 1'b1);

        // ADD x1,x2,x3 appears one cycle later at address 0
        set_req(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        check("add_valid", bus.instr_valid, 1'b1);
        check("add_instr", bus.instr, 32'h003100B3);
        check("add_addr", bus.instr_addr, 32'h0);

        // Reset mid-operation discards the pending entry immediately
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.instr_valid, 1'b0);
        check("midrst_instr", bus.instr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_ready", bus.req_ready, 1'b1);

        // SUB then BNE, held in the FIFO until drained
        set_req(3'd0, 4'd1, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        set_req(3'd4, 4'd1, 5'd0, 5'd1, 5'd0, -32'sd8);
        tick();
        bus.req_valid = 1'b0;
        check("full_ready", bus.req_ready, 1'b0);
        check("sub_instr", bus.instr, 32'h403100B3);
        check("sub_addr", bus.instr_addr, 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        check("bne_instr", bus.instr, 32'hFE009CE3);
        check("bne_addr", bus.instr_addr, 32'h4);
        tick();
        check("drained_valid", bus.instr_valid, 1'b0);

        // Backpressure with three requests, then simultaneous pop and push
        bus.instr_ready = 1'b0;
        set_req(3'd0, 4'd0, 5'd4, 5'd0, 5'd0, 32'd0);
        tick();
        check("bp1_ready", bus.req_ready, 1'b1);
        set_req(3'd0, 4'd5, 5'd5, 5'd0, 5'd0, 32'd0);
        tick();
        check("bp2_ready", bus.req_ready, 1'b0);
        set_req(3'd0, 4'd8, 5'd6, 5'd0, 5'd0, 32'd0);
        tick();
        check("bp3_ready", bus.req_ready, 1'b0);
        check("bp_head_instr", bus.instr, 32'h00000233);
        check("bp_head_addr", bus.instr_addr, 32'h8);
        bus.instr_ready = 1'b1;
        #1;
        check("no_passthru", bus.req_ready, 1'b0);
        tick();
        check("bp_pop_ready", bus.req_ready, 1'b1);
        check("bp_xor_instr", bus.instr, 32'h000042B3);
        check("bp_xor_addr", bus.instr_addr, 32'hC);
        tick();
        bus.req_valid = 1'b0;
        check("pp_valid", bus.instr_valid, 1'b1);
        check("pp_or_instr", bus.instr, 32'h00006333);
        check("pp_or_addr", bus.instr_addr, 32'h10);
        tick();
        check("bp_empty", bus.instr_valid, 1'b0);

        // STORE sw x3,-4(x2)
        bus.instr_ready = 1'b0;
        set_req(3'd3, 4'd2, 5'd0, 5'd2, 5'd3, -32'sd4);
        tick();
        bus.req_valid = 1'b0;
        check("sw_instr", bus.instr, 32'hFE312E23);
        check("sw_addr", bus.instr_addr, 32'h14);
        bus.instr_ready = 1'b1;
        tick();

        // Illegal requests: ADDI out of range, odd branch offset, reserved format
        set_req(3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        check("e1_pulse", bus.err_pulse, 1'b1);
        check("e1_cnt", bus.err_cnt, 8'd1);
        set_req(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        tick();
        check("e2_cnt", bus.err_cnt, 8'd2);
        set_req(3'd7, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        check("e3_pulse", bus.err_pulse, 1'b1);
        check("e3_cnt", bus.err_cnt, 8'd3);
        check("e3_no_entry", bus.instr_valid, 1'b0);
        bus.req_valid = 1'b0;
        tick();
        check("e_pulse_low", bus.err_pulse, 1'b0);
        check("e_still_empty", bus.instr_valid, 1'b0);
        bus.instr_ready = 1'b0;
        set_req(3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        bus.req_valid = 1'b0;
        check("addi_instr", bus.instr, 32'h00500093);
        check("ptr_unchanged", bus.instr_addr, 32'h18);
        bus.instr_ready = 1'b1;
        tick();

        // base_load together with JAL x1,8
        bus.instr_ready = 1'b0;
        bus.base_load = 1'b1;
        bus.base_addr = 32'h100;
        set_req(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        tick();
        bus.base_load = 1'b0;
        check("jal_instr", bus.instr, 32'h008000EF);
        check("jal_addr", bus.instr_addr, 32'h100);
        set_req(3'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("after_jal_addr", bus.instr_addr, 32'h104);
        bus.base_load = 1'b1;
        bus.base_addr = 32'h200;
        tick();
        bus.base_load = 1'b0;
        check("base_keeps_entry", bus.instr_addr, 32'h104);
        bus.instr_ready = 1'b1;
        tick();

        // Error counter saturation
        set_req(3'd7, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (256) tick();
        check("sat_cnt", bus.err_cnt, 8'd255);
        check("sat_pulse", bus.err_pulse, 1'b1);
        bus.req_valid = 1'b0;
        tick();
        check("sat_hold", bus.err_cnt, 8'd255);
        check("sat_pulse_low", bus.err_pulse, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
